// File: rtl/ifu_pkg.sv
// ifu_pkg: shared widths, reset pc, fetch FSM states and buffered fetch entry type
package ifu_pkg;
    localparam int XLEN = 64;
    localparam int IW = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h8000_0000;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} fetch_state_t;
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [IW-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: instruction-memory request bus plus decode-side valid/ready handshake
interface inst_fetch_unit_if;
    import ifu_pkg::*;
    logic imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic imem_gnt_i;
    logic imem_rvalid_i;
    logic [IW-1:0] imem_rdata_i;
    logic inst_valid_o;
    logic inst_ready_i;
    logic [IW-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;
    modport master (
        output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
    modport slave (
        input imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i
    );
endinterface

// File: rtl/inst_fetch_unit_fifo.sv
// fetch_fifo: registered FIFO of {pc, inst} entries with synchronous clear
module fetch_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         clear,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [AW:0]  count,
    output logic         full,
    output logic         empty
);
    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic do_push, do_pop;

    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= din;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: single-outstanding instruction fetch with a small {pc, inst} buffer toward decode
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_en_o,
    input  logic            flush_i,
    inst_fetch_unit_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t state, next;
    logic [XLEN-1:0] addr_q;
    logic outstanding, req, push, pop, space, full, empty;
    logic [CW-1:0] count;
    fetch_entry_t head;

    // Counting the in-flight response keeps rvalid from ever landing on a full buffer
    assign space = (count + CW'(outstanding)) < CW'(FIFO_DEPTH) && !full;

    always_comb begin
        next = state;
        req = 1'b0;
        pc_en_o = 1'b0;
        push = 1'b0;
        case (state)
            IDLE: next = REQ;
            REQ: begin
                req = space;
                if (req && bus.imem_gnt_i) begin
                    pc_en_o = !flush_i;
                    next = flush_i ? DROP : WAIT;
                end
            end
            WAIT: begin
                push = bus.imem_rvalid_i && !flush_i;
                next = bus.imem_rvalid_i ? REQ : (flush_i ? DROP : WAIT);
            end
            DROP: next = bus.imem_rvalid_i ? REQ : DROP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            addr_q <= '0;
            outstanding <= 1'b0;
        end else begin
            state <= next;
            if (req && bus.imem_gnt_i) addr_q <= pc_i;
            outstanding <= (req && bus.imem_gnt_i) ? 1'b1 : (bus.imem_rvalid_i ? 1'b0 : outstanding);
        end
    end

    assign pop = bus.inst_valid_o && bus.inst_ready_i;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (flush_i),
        .din   ('{pc: addr_q, inst: bus.imem_rdata_i}),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.imem_req_o = req;
    assign bus.imem_addr_o = req ? pc_i : '0;
    assign bus.inst_valid_o = !empty;
    assign bus.inst_o = head.inst;
    assign bus.inst_pc_o = head.pc;
endmodule
